// File: rtl/cluster_mul_share_arb.sv
// cluster_mul_share_arb: round-robin sharing of one pipelined 13x9 multiplier with tagged, backpressured responses
module cluster_mul_share_arb #(
  parameter int NUM_REQ = 4,
  parameter int ID_W = 2,
  parameter int MUL_LAT = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*13-1:0]  req_a,
  input  logic [NUM_REQ*9-1:0]   req_b,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   mul_ce,
  output logic [12:0]            mul_din0,
  output logic [8:0]             mul_din1,
  input  logic [12:0]            mul_dout,
  output logic                   rsp_valid,
  output logic [ID_W-1:0]        rsp_id,
  output logic [12:0]            rsp_data,
  input  logic                   rsp_ready,
  output logic                   busy
);
  logic [ID_W-1:0] ptr_q, ptr_d, g, idx;
  logic [MUL_LAT-1:0] v_q, v_d;
  logic [MUL_LAT-1:0][ID_W-1:0] t_q, t_d;
  logic issue;
  // scan downward from ptr+NUM_REQ-1 so the requester closest to ptr wins last
  always_comb begin
    g = '0;
    idx = '0;
    issue = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = ID_W'((int'(ptr_q) + k) % NUM_REQ);
      if (req_valid[idx]) begin
        g = idx;
        issue = ~reset;
      end
    end
  end
  assign rsp_valid = v_q[MUL_LAT-1] & ~reset;
  assign rsp_id    = reset ? '0 : t_q[MUL_LAT-1];
  assign rsp_data  = mul_dout;
  assign busy      = (|v_q) & ~reset;
  assign mul_ce    = ~(rsp_valid & ~rsp_ready);
  assign req_ready = (issue & mul_ce) ? NUM_REQ'(1) << g : '0;
  assign mul_din0  = issue ? req_a[13*int'(g) +: 13] : '0;
  assign mul_din1  = issue ? req_b[9*int'(g) +: 9] : '0;
  always_comb begin
    v_d   = mul_ce ? {v_q[MUL_LAT-2:0], issue} : v_q;
    t_d   = mul_ce ? {t_q[MUL_LAT-2:0], g} : t_q;
    ptr_d = (mul_ce & issue) ? (g == ID_W'(NUM_REQ - 1) ? '0 : g + ID_W'(1)) : ptr_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
      v_q   <= '0;
      t_q   <= '0;
    end else begin
      ptr_q <= ptr_d;
      v_q   <= v_d;
      t_q   <= t_d;
    end
  end
endmodule

// File: tb/tb_cluster_mul_share_arb.sv
// tb_cluster_mul_share_arb: directed stimulus with a response scoreboard and a behavioural 3-stage multiplier
module tb_cluster_mul_share_arb;
  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [51:0] req_a;
  logic [35:0] req_b;
  logic [3:0]  req_ready;
  logic        mul_ce;
  logic [12:0] mul_din0;
  logic [8:0]  mul_din1;
  logic [12:0] mul_dout;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [12:0] rsp_data;
  logic        rsp_ready;
  logic        busy;

  cluster_mul_share_arb dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .mul_ce(mul_ce), .mul_din0(mul_din0), .mul_din1(mul_din1),
    .mul_dout(mul_dout), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_ready(rsp_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  logic signed [22:0] prod;
  logic [12:0] m1, m2, m3;
  assign prod = $signed(mul_din0) * $signed({1'b0, mul_din1});
  always @(posedge clk) if (mul_ce) begin
    m1 <= prod[12:0];
    m2 <= m1;
    m3 <= m2;
  end
  assign mul_dout = m3;

  typedef struct packed {logic [1:0] id; logic [12:0] data;} exp_t;
  exp_t sb[$];
  exp_t e;
  logic [12:0] exp_p [4];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (reset) sb.delete();
    else begin
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected actual_id=%0d required=none", rsp_id);
        end else begin
          e = sb.pop_front();
          chk("sb_id", 32'(rsp_id), 32'(e.id));
          chk("sb_data", 32'(rsp_data), 32'(e.data));
        end
      end
      for (int i = 0; i < 4; i++)
        if (req_valid[i] && req_ready[i]) sb.push_back({2'(i), exp_p[i]});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] v, input logic rdy, input logic rst);
    req_valid = v;
    rsp_ready = rdy;
    reset = rst;
    #1;
  endtask

  task automatic set_op(input int i, input logic [12:0] a, input logic [8:0] b, input logic [12:0] p);
    req_a[13*i +: 13] = a;
    req_b[9*i +: 9] = b;
    exp_p[i] = p;
  endtask

  initial begin
    reset = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b1;
    req_a = '0;
    req_b = '0;
    for (int i = 0; i < 4; i++) exp_p[i] = '0;
    // 1: reset outputs, then single request from requester 1
    tick(); drive(4'hF, 1, 1);
    tick(); drive(4'hF, 1, 1);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_id", 32'(rsp_id), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_mul_ce", 32'(mul_ce), 1);
    chk("rst_din0", 32'(mul_din0), 0);
    chk("rst_din1", 32'(mul_din1), 0);
    tick(); set_op(1, 13'h1FFD, 9'd5, 13'h1FF1); drive(4'b0010, 1, 0);
    chk("t1_grant", 32'(req_ready), 32'b0010);
    chk("t1_din0", 32'(mul_din0), 32'h1FFD);
    chk("t1_din1", 32'(mul_din1), 5);
    tick(); drive(0, 1, 0);
    chk("t1_busy", 32'(busy), 1);
    chk("t1_early", 32'(rsp_valid), 0);
    tick(); drive(0, 1, 0);
    chk("t1_early2", 32'(rsp_valid), 0);
    tick(); drive(0, 1, 0);
    chk("t1_rsp_valid", 32'(rsp_valid), 1);
    chk("t1_rsp_id", 32'(rsp_id), 1);
    chk("t1_rsp_data", 32'(rsp_data), 32'h1FF1);
    // 2: truncation
    tick(); set_op(0, 13'h0FFF, 9'd511, 13'h0E01); drive(4'b0001, 1, 0);
    chk("t2_grant_a", 32'(req_ready), 32'b0001);
    tick(); set_op(0, 13'h1000, 9'd1, 13'h1000); drive(4'b0001, 1, 0);
    chk("t2_grant_b", 32'(req_ready), 32'b0001);
    tick(); drive(0, 1, 0);
    tick(); drive(0, 1, 0);
    chk("t2_trunc", 32'(rsp_data), 32'h0E01);
    tick(); drive(0, 1, 0);
    chk("t2_neg", 32'(rsp_data), 32'h1000);
    // 3: round robin from a freshly reset pointer
    tick();
    set_op(0, 13'd2, 9'd3, 13'h0006);
    set_op(1, 13'h1FFF, 9'd7, 13'h1FF9);
    set_op(2, 13'h0064, 9'd10, 13'h03E8);
    set_op(3, 13'h1FCE, 9'd200, 13'h18F0);
    drive(0, 1, 1);
    for (int k = 0; k < 11; k++) begin
      tick(); drive(k < 8 ? 4'hF : 4'h0, 1, 0);
      if (k < 8) chk("t3_grant", 32'(req_ready), 32'(1 << (k % 4)));
      if (k >= 3) begin
        chk("t3_rsp_valid", 32'(rsp_valid), 1);
        chk("t3_rsp_id", 32'(rsp_id), 32'((k - 3) % 4));
      end
    end
    // 4: backpressure with a request waiting during the stall
    for (int k = 0; k < 11; k++) begin
      tick();
      drive(k < 3 ? 4'(1 << k) : (k <= 7 ? 4'b1000 : 4'b0000), !(k >= 3 && k <= 6), 0);
      if (k < 3) chk("t4_grant", 32'(req_ready), 32'(1 << k));
      if (k >= 3 && k <= 6) begin
        chk("t4_stall_valid", 32'(rsp_valid), 1);
        chk("t4_stall_id", 32'(rsp_id), 0);
        chk("t4_stall_data", 32'(rsp_data), 32'h0006);
        chk("t4_stall_ready", 32'(req_ready), 0);
        chk("t4_stall_ce", 32'(mul_ce), 0);
      end
      if (k == 7) chk("t4_release_grant", 32'(req_ready), 32'b1000);
      if (k >= 7) begin
        chk("t4_rsp_valid", 32'(rsp_valid), 1);
        chk("t4_rsp_id", 32'(rsp_id), 32'(k - 7));
      end
    end
    // 5: reset with operations in flight
    for (int k = 0; k < 3; k++) begin
      tick(); drive(4'hF, 1, 0);
      chk("t5_grant", 32'(req_ready), 32'(1 << k));
    end
    tick(); drive(4'hF, 1, 1);
    chk("t5_rst_ready", 32'(req_ready), 0);
    chk("t5_rst_rsp", 32'(rsp_valid), 0);
    chk("t5_rst_busy", 32'(busy), 0);
    tick(); drive(4'b1010, 1, 0);
    chk("t5_lowest", 32'(req_ready), 32'b0010);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_quiet0", 32'(rsp_valid), 0);
    tick(); drive(0, 1, 0);
    chk("t5_quiet1", 32'(rsp_valid), 0);
    tick(); drive(0, 1, 0);
    chk("t5_quiet2", 32'(rsp_valid), 0);
    tick(); drive(0, 1, 0);
    chk("t5_rsp_valid", 32'(rsp_valid), 1);
    chk("t5_rsp_id", 32'(rsp_id), 1);
    // 6: sparse traffic from requester 2
    tick(); set_op(2, 13'h1FF9, 9'd9, 13'h1FC1); drive(4'b0100, 1, 0);
    for (int k = 0; k < 11; k++) begin
      if (k > 0) begin
        tick(); drive((k < 7 && k % 2 == 0) ? 4'b0100 : 4'b0000, 1, 0);
      end
      if (k < 7 && k % 2 == 0) chk("t6_grant", 32'(req_ready), 32'b0100);
      chk("t6_rsp_valid", 32'(rsp_valid), 32'(k >= 3 && k <= 9 && k % 2 == 1));
      if (k >= 3 && k <= 9 && k % 2 == 1) chk("t6_rsp_id", 32'(rsp_id), 2);
      chk("t6_busy", 32'(busy), 32'(k >= 1 && k <= 9));
    end
    repeat (3) tick();
    chk("sb_empty", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
